// File: rtl/decode_stage.sv
// MIPS ID stage: register file, branch and jump resolution in ID, hazard detection,
// and the ID/EX pipeline register that feeds execute.
module decode_stage #(
  parameter int NB_BITS = 32,
  parameter int NB_REG  = 5,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_if_id_pc,
  input  logic [NB_BITS-1:0] i_if_id_instr,
  input  logic               i_ex_mem_reg_write,
  input  logic               i_ex_mem_mem_read,
  input  logic [NB_REG-1:0]  i_ex_mem_rd,
  input  logic [NB_BITS-1:0] i_ex_mem_data,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_BITS-1:0] i_wb_data,
  output logic               o_pc_we,
  output logic               o_if_id_we,
  output logic               o_ctr_beq,
  output logic               o_ctr_jmp,
  output logic               o_ctr_flush,
  output logic [NB_BITS-1:0] o_brq_addr,
  output logic [NB_BITS-1:0] o_jmp_addr,
  output logic [NB_BITS-1:0] o_id_ex_pc,
  output logic [NB_BITS-1:0] o_id_ex_rs_data,
  output logic [NB_BITS-1:0] o_id_ex_rt_data,
  output logic [NB_BITS-1:0] o_id_ex_imm,
  output logic [NB_REG-1:0]  o_id_ex_rs,
  output logic [NB_REG-1:0]  o_id_ex_rt,
  output logic [NB_REG-1:0]  o_id_ex_rd,
  output logic [NB_OP-1:0]   o_id_ex_opcode,
  output logic [NB_OP-1:0]   o_id_ex_funct,
  output logic               o_id_ex_reg_write,
  output logic               o_id_ex_mem_read,
  output logic               o_id_ex_mem_write,
  output logic               o_id_ex_alu_src,
  output logic               o_id_ex_link
);

  localparam logic [NB_OP-1:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                               OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDIU = 6'h09,
                               OP_SLTI  = 6'h0A, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                               OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                               OP_SW    = 6'h2B;
  localparam logic [NB_OP-1:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03,
                               F_JR   = 6'h08, F_JALR = 6'h09, F_ADDU = 6'h21,
                               F_SUBU = 6'h23, F_AND  = 6'h24, F_OR  = 6'h25,
                               F_XOR  = 6'h26, F_NOR  = 6'h27, F_SLT = 6'h2A;
  localparam int NUM_REGS = 2 ** NB_REG;

  typedef struct packed {
    logic [NB_BITS-1:0] pc;
    logic [NB_BITS-1:0] rs_data;
    logic [NB_BITS-1:0] rt_data;
    logic [NB_BITS-1:0] imm;
    logic [NB_REG-1:0]  rs;
    logic [NB_REG-1:0]  rt;
    logic [NB_REG-1:0]  rd;
    logic [NB_OP-1:0]   opcode;
    logic [NB_OP-1:0]   funct;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               link;
  } id_ex_t;

  id_ex_t             id_ex_d, id_ex_q;
  logic [NB_BITS-1:0] rf_d [NUM_REGS];
  logic [NB_BITS-1:0] rf_q [NUM_REGS];

  logic [NB_OP-1:0]   opcode, funct;
  logic [NB_REG-1:0]  rs, rt, rd, dest;
  logic [NB_BITS-1:0] imm_sext, imm_ext, rf_rs, rf_rt, op_rs, op_rt;
  logic reg_write, mem_read, mem_write, alu_src, link, zext;
  logic use_rs, use_rt, is_beq, is_bne, is_j, is_jr;
  logic br_rs, br_rt, load_use, ex_hz, mem_hz, stall, go, ops_eq;

  assign opcode   = i_if_id_instr[31:26];
  assign rs       = i_if_id_instr[25:21];
  assign rt       = i_if_id_instr[20:16];
  assign rd       = i_if_id_instr[15:11];
  assign funct    = i_if_id_instr[5:0];
  assign imm_sext = {{(NB_BITS-16){i_if_id_instr[15]}}, i_if_id_instr[15:0]};
  assign imm_ext  = zext ? {{(NB_BITS-16){1'b0}}, i_if_id_instr[15:0]} : imm_sext;

  always_comb begin
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; alu_src = 1'b0; link = 1'b0;
    zext = 1'b0; use_rs = 1'b0; use_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0; is_jr = 1'b0;
    dest = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin reg_write = 1'b1; dest = rd; use_rt = 1'b1; end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
            reg_write = 1'b1; dest = rd; use_rs = 1'b1; use_rt = 1'b1;
          end
          F_JR:   begin use_rs = 1'b1; is_jr = 1'b1; end
          F_JALR: begin
            use_rs = 1'b1; is_jr = 1'b1; link = 1'b1; reg_write = 1'b1; dest = rd;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_SLTI: begin reg_write = 1'b1; alu_src = 1'b1; dest = rt; use_rs = 1'b1; end
      OP_ANDI, OP_ORI, OP_XORI: begin
        reg_write = 1'b1; alu_src = 1'b1; dest = rt; use_rs = 1'b1; zext = 1'b1;
      end
      OP_LUI: begin reg_write = 1'b1; alu_src = 1'b1; dest = rt; end
      OP_LW:  begin
        reg_write = 1'b1; mem_read = 1'b1; alu_src = 1'b1; dest = rt; use_rs = 1'b1;
      end
      OP_SW:  begin mem_write = 1'b1; alu_src = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ: begin is_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin is_j = 1'b1; link = 1'b1; reg_write = 1'b1; dest = NB_REG'(31); end
      default: ;
    endcase
    if (dest == '0) reg_write = 1'b0;
  end

  // Register file read with write-through, then EX/MEM bypass for the ID compare only.
  assign rf_rs = (rs == '0) ? '0 : (i_wb_we && i_wb_addr == rs) ? i_wb_data : rf_q[rs];
  assign rf_rt = (rt == '0) ? '0 : (i_wb_we && i_wb_addr == rt) ? i_wb_data : rf_q[rt];
  assign op_rs = (i_ex_mem_reg_write && !i_ex_mem_mem_read && i_ex_mem_rd != '0 &&
                  i_ex_mem_rd == rs) ? i_ex_mem_data : rf_rs;
  assign op_rt = (i_ex_mem_reg_write && !i_ex_mem_mem_read && i_ex_mem_rd != '0 &&
                  i_ex_mem_rd == rt) ? i_ex_mem_data : rf_rt;
  assign ops_eq = (op_rs == op_rt);

  assign br_rs    = is_beq | is_bne | is_jr;
  assign br_rt    = is_beq | is_bne;
  assign load_use = id_ex_q.mem_read &&
                    ((use_rs && rs == id_ex_q.rt) || (use_rt && rt == id_ex_q.rt));
  assign ex_hz    = id_ex_q.reg_write &&
                    ((br_rs && rs == id_ex_q.rd) || (br_rt && rt == id_ex_q.rd));
  assign mem_hz   = i_ex_mem_mem_read &&
                    ((br_rs && rs == i_ex_mem_rd) || (br_rt && rt == i_ex_mem_rd));
  // Fetch controls are forced to their idle values while reset is held.
  assign stall    = i_rst && (load_use || ex_hz || mem_hz);
  assign go       = i_rst && !stall;

  assign o_pc_we     = !stall;
  assign o_if_id_we  = !stall;
  assign o_ctr_beq   = go && ((is_beq && ops_eq) || (is_bne && !ops_eq));
  assign o_ctr_jmp   = go && (is_j || is_jr);
  assign o_ctr_flush = o_ctr_beq || o_ctr_jmp;
  assign o_brq_addr  = i_if_id_pc + {imm_sext[NB_BITS-3:0], 2'b00};
  assign o_jmp_addr  = is_j ? {i_if_id_pc[NB_BITS-1:28], i_if_id_instr[25:0], 2'b00} : op_rs;

  always_comb begin
    rf_d = rf_q;
    if (i_wb_we && i_wb_addr != '0) rf_d[i_wb_addr] = i_wb_data;
  end

  always_comb begin
    id_ex_d = '{pc: i_if_id_pc, rs_data: rf_rs, rt_data: rf_rt, imm: imm_ext,
                rs: rs, rt: rt, rd: dest, opcode: opcode, funct: funct,
                reg_write: reg_write, mem_read: mem_read, mem_write: mem_write,
                alu_src: alu_src, link: link};
    if (stall) id_ex_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      id_ex_q <= '0;
    end else begin
      rf_q    <= rf_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign o_id_ex_pc        = id_ex_q.pc;
  assign o_id_ex_rs_data   = id_ex_q.rs_data;
  assign o_id_ex_rt_data   = id_ex_q.rt_data;
  assign o_id_ex_imm       = id_ex_q.imm;
  assign o_id_ex_rs        = id_ex_q.rs;
  assign o_id_ex_rt        = id_ex_q.rt;
  assign o_id_ex_rd        = id_ex_q.rd;
  assign o_id_ex_opcode    = id_ex_q.opcode;
  assign o_id_ex_funct     = id_ex_q.funct;
  assign o_id_ex_reg_write = id_ex_q.reg_write;
  assign o_id_ex_mem_read  = id_ex_q.mem_read;
  assign o_id_ex_mem_write = id_ex_q.mem_write;
  assign o_id_ex_alu_src   = id_ex_q.alu_src;
  assign o_id_ex_link      = id_ex_q.link;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table plus hand-written hazard, forwarding
// and reset sequences.
module tb_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_if_id_pc, i_if_id_instr, i_ex_mem_data, i_wb_data;
  logic        i_ex_mem_reg_write, i_ex_mem_mem_read, i_wb_we;
  logic [4:0]  i_ex_mem_rd, i_wb_addr;
  logic        o_pc_we, o_if_id_we, o_ctr_beq, o_ctr_jmp, o_ctr_flush;
  logic [31:0] o_brq_addr, o_jmp_addr, o_id_ex_pc, o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm;
  logic [4:0]  o_id_ex_rs, o_id_ex_rt, o_id_ex_rd;
  logic [5:0]  o_id_ex_opcode, o_id_ex_funct;
  logic        o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_mem_write, o_id_ex_alu_src, o_id_ex_link;

  always #5 i_clk = ~i_clk;

  decode_stage dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_id_pc(i_if_id_pc), .i_if_id_instr(i_if_id_instr),
    .i_ex_mem_reg_write(i_ex_mem_reg_write), .i_ex_mem_mem_read(i_ex_mem_mem_read),
    .i_ex_mem_rd(i_ex_mem_rd), .i_ex_mem_data(i_ex_mem_data),
    .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_pc_we(o_pc_we), .o_if_id_we(o_if_id_we),
    .o_ctr_beq(o_ctr_beq), .o_ctr_jmp(o_ctr_jmp), .o_ctr_flush(o_ctr_flush),
    .o_brq_addr(o_brq_addr), .o_jmp_addr(o_jmp_addr),
    .o_id_ex_pc(o_id_ex_pc), .o_id_ex_rs_data(o_id_ex_rs_data),
    .o_id_ex_rt_data(o_id_ex_rt_data), .o_id_ex_imm(o_id_ex_imm),
    .o_id_ex_rs(o_id_ex_rs), .o_id_ex_rt(o_id_ex_rt), .o_id_ex_rd(o_id_ex_rd),
    .o_id_ex_opcode(o_id_ex_opcode), .o_id_ex_funct(o_id_ex_funct),
    .o_id_ex_reg_write(o_id_ex_reg_write), .o_id_ex_mem_read(o_id_ex_mem_read),
    .o_id_ex_mem_write(o_id_ex_mem_write), .o_id_ex_alu_src(o_id_ex_alu_src),
    .o_id_ex_link(o_id_ex_link)
  );

  // tsel: 0 = no target check, 1 = branch target, 2 = jump target
  typedef struct {
    string       name;
    logic [31:0] instr, pc;
    logic        rw, mr, mw, as, lk;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        beq, jmp;
    int          tsel;
    logic [31:0] tgt;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic clr_side();
    i_ex_mem_reg_write = 1'b0; i_ex_mem_mem_read = 1'b0; i_ex_mem_rd = '0; i_ex_mem_data = '0;
    i_wb_we = 1'b0; i_wb_addr = '0; i_wb_data = '0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_if_id_instr = 32'h0; i_wb_we = 1'b1; i_wb_addr = a; i_wb_data = d;
    @(posedge i_clk);
  endtask

  vec_t vecs[12];
  int   stalls;
  bit   done;

  initial begin
    vecs[0]  = '{"addu",   32'h00422821, 32'h100, 1,0,0,0,0, 5'd5,  32'h00002821, 0,0, 0, 32'h0};
    vecs[1]  = '{"addiu",  32'h2406FFFF, 32'h104, 1,0,0,1,0, 5'd6,  32'hFFFFFFFF, 0,0, 0, 32'h0};
    vecs[2]  = '{"ori",    32'h34278000, 32'h108, 1,0,0,1,0, 5'd7,  32'h00008000, 0,0, 0, 32'h0};
    vecs[3]  = '{"lw",     32'h8C220000, 32'h10C, 1,1,0,1,0, 5'd2,  32'h00000000, 0,0, 0, 32'h0};
    vecs[4]  = '{"sw",     32'hAC220004, 32'h110, 0,0,1,1,0, 5'd0,  32'h00000004, 0,0, 0, 32'h0};
    vecs[5]  = '{"addu_r0",32'h00220021, 32'h114, 0,0,0,0,0, 5'd0,  32'h00000021, 0,0, 0, 32'h0};
    vecs[6]  = '{"beq",    32'h10220004, 32'h104, 0,0,0,0,0, 5'd0,  32'h00000004, 1,0, 1, 32'h114};
    vecs[7]  = '{"bne",    32'h14220004, 32'h104, 0,0,0,0,0, 5'd0,  32'h00000004, 0,0, 1, 32'h114};
    vecs[8]  = '{"jal",    32'h0C000040, 32'h008, 1,0,0,0,1, 5'd31, 32'h00000040, 0,1, 2, 32'h100};
    vecs[9]  = '{"jr",     32'h00600008, 32'h120, 0,0,0,0,0, 5'd0,  32'h00000008, 0,1, 2, 32'h10};
    vecs[10] = '{"illegal",32'hFC000000, 32'h124, 0,0,0,0,0, 5'd0,  32'h00000000, 0,0, 0, 32'h0};
    vecs[11] = '{"andi",   32'h3068FFFF, 32'h128, 1,0,0,1,0, 5'd8,  32'h0000FFFF, 0,0, 0, 32'h0};

    i_rst = 1'b0; i_if_id_pc = '0; i_if_id_instr = '0;
    clr_side();

    // reset state
    #12;
    chk("rst_id_ex_reg_write", {31'b0, o_id_ex_reg_write}, 32'h0);
    chk("rst_id_ex_pc", o_id_ex_pc, 32'h0);
    chk("rst_pc_we", {31'b0, o_pc_we}, 32'h1);
    chk("rst_if_id_we", {31'b0, o_if_id_we}, 32'h1);
    @(negedge i_clk) i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("nop_reg_write", {31'b0, o_id_ex_reg_write}, 32'h0);
    chk("nop_ctrl", {27'b0, o_id_ex_mem_read, o_id_ex_mem_write, o_id_ex_alu_src, o_id_ex_link,
                     o_ctr_flush}, 32'h0);
    chk("nop_pc_we", {31'b0, o_pc_we}, 32'h1);

    // same-cycle WB write and ID read
    @(negedge i_clk);
    i_wb_we = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'h10;
    i_if_id_instr = 32'h00602021; i_if_id_pc = 32'h40;
    @(posedge i_clk); #1;
    chk("wb_bypass_rs_data", o_id_ex_rs_data, 32'h10);
    chk("wb_bypass_rd", {27'b0, o_id_ex_rd}, 32'd4);
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    @(negedge i_clk) clr_side();
    @(posedge i_clk);

    // decode table, one NOP between entries
    for (int i = 0; i < 12; i++) begin
      @(negedge i_clk);
      i_if_id_instr = vecs[i].instr; i_if_id_pc = vecs[i].pc;
      #1;
      chk({vecs[i].name, "_pc_we"}, {31'b0, o_pc_we}, 32'h1);
      chk({vecs[i].name, "_beq"}, {31'b0, o_ctr_beq}, {31'b0, vecs[i].beq});
      chk({vecs[i].name, "_jmp"}, {31'b0, o_ctr_jmp}, {31'b0, vecs[i].jmp});
      chk({vecs[i].name, "_flush"}, {31'b0, o_ctr_flush}, {31'b0, vecs[i].beq | vecs[i].jmp});
      if (vecs[i].tsel == 1) chk({vecs[i].name, "_brq_addr"}, o_brq_addr, vecs[i].tgt);
      if (vecs[i].tsel == 2) chk({vecs[i].name, "_jmp_addr"}, o_jmp_addr, vecs[i].tgt);
      @(posedge i_clk); #1;
      chk({vecs[i].name, "_ctrl"},
          {27'b0, o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_mem_write, o_id_ex_alu_src, o_id_ex_link},
          {27'b0, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].as, vecs[i].lk});
      chk({vecs[i].name, "_rd"}, {27'b0, o_id_ex_rd}, {27'b0, vecs[i].rd});
      chk({vecs[i].name, "_imm"}, o_id_ex_imm, vecs[i].imm);
      chk({vecs[i].name, "_id_ex_pc"}, o_id_ex_pc, vecs[i].pc);
      @(negedge i_clk) i_if_id_instr = 32'h0;
      @(posedge i_clk);
    end

    // load-use: LW $2 then ADDU $5,$2,$2
    @(negedge i_clk) begin i_if_id_instr = 32'h8C220000; i_if_id_pc = 32'h50; end
    @(posedge i_clk);
    @(negedge i_clk) begin i_if_id_instr = 32'h00422821; i_if_id_pc = 32'h54; end
    #1;
    chk("lu_pc_we", {31'b0, o_pc_we}, 32'h0);
    chk("lu_if_id_we", {31'b0, o_if_id_we}, 32'h0);
    @(posedge i_clk); #1;
    chk("lu_bubble", {29'b0, o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_alu_src}, 32'h0);
    @(negedge i_clk); #1;
    chk("lu_release_pc_we", {31'b0, o_pc_we}, 32'h1);
    @(posedge i_clk); #1;
    chk("lu_addu_rd", {27'b0, o_id_ex_rd}, 32'd5);
    chk("lu_addu_reg_write", {31'b0, o_id_ex_reg_write}, 32'h1);
    chk("lu_addu_rs_data", o_id_ex_rs_data, 32'd7);

    // ADDIU $6,$0,-1 then BEQ $6,$0: one stall, then EX/MEM forwarded, not taken
    @(negedge i_clk) begin i_if_id_instr = 32'h2406FFFF; i_if_id_pc = 32'h200; end
    @(posedge i_clk);
    @(negedge i_clk) begin i_if_id_instr = 32'h10C00004; i_if_id_pc = 32'h204; end
    #1;
    chk("fwd_stall_pc_we", {31'b0, o_pc_we}, 32'h0);
    chk("fwd_stall_beq", {31'b0, o_ctr_beq}, 32'h0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_ex_mem_reg_write = 1'b1; i_ex_mem_rd = 5'd6; i_ex_mem_data = 32'hFFFFFFFF;
    #1;
    chk("fwd_pc_we", {31'b0, o_pc_we}, 32'h1);
    chk("fwd_beq_not_taken", {31'b0, o_ctr_beq}, 32'h0);
    chk("fwd_flush", {31'b0, o_ctr_flush}, 32'h0);
    chk("fwd_brq_addr", o_brq_addr, 32'h214);
    @(posedge i_clk);
    @(negedge i_clk) begin clr_side(); i_if_id_instr = 32'h0; end
    @(posedge i_clk);

    // LW $2 then BNE $2,$1: two stall cycles, then WB write-through decides
    @(negedge i_clk) begin i_if_id_instr = 32'h8C220000; i_if_id_pc = 32'h2FC; end
    @(posedge i_clk);
    stalls = 0; done = 1'b0;
    for (int k = 0; k < 5 && !done; k++) begin
      @(negedge i_clk);
      clr_side();
      i_if_id_instr = 32'h14410002; i_if_id_pc = 32'h300;
      if (k == 1) begin
        i_ex_mem_reg_write = 1'b1; i_ex_mem_mem_read = 1'b1; i_ex_mem_rd = 5'd2;
      end else if (k >= 2) begin
        i_wb_we = 1'b1; i_wb_addr = 5'd2; i_wb_data = 32'h55;
      end
      #1;
      if (o_pc_we) done = 1'b1;
      else begin
        stalls++;
        @(posedge i_clk);
      end
    end
    chk("ld_br_stall_cycles", stalls, 32'd2);
    chk("ld_br_bne_taken", {31'b0, o_ctr_beq}, 32'h1);
    chk("ld_br_flush", {31'b0, o_ctr_flush}, 32'h1);
    chk("ld_br_brq_addr", o_brq_addr, 32'h308);
    @(posedge i_clk);
    @(negedge i_clk) begin clr_side(); i_if_id_instr = 32'h0; end
    @(posedge i_clk);

    // reset pulsed in the middle of an ADDIU/BEQ stall
    @(negedge i_clk) begin i_if_id_instr = 32'h2406FFFF; i_if_id_pc = 32'h400; end
    @(posedge i_clk);
    @(negedge i_clk) begin i_if_id_instr = 32'h10C00004; i_if_id_pc = 32'h404; end
    #1;
    chk("mid_rst_pre_stall", {31'b0, o_pc_we}, 32'h0);
    #1 i_rst = 1'b0;
    #1;
    chk("mid_rst_pc_we", {31'b0, o_pc_we}, 32'h1);
    chk("mid_rst_if_id_we", {31'b0, o_if_id_we}, 32'h1);
    chk("mid_rst_fetch_ctrl", {29'b0, o_ctr_beq, o_ctr_jmp, o_ctr_flush}, 32'h0);
    chk("mid_rst_id_ex_ctrl", {27'b0, o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_mem_write,
                               o_id_ex_alu_src, o_id_ex_link}, 32'h0);
    chk("mid_rst_id_ex_rd", {27'b0, o_id_ex_rd}, 32'h0);
    chk("mid_rst_id_ex_imm", o_id_ex_imm, 32'h0);
    chk("mid_rst_id_ex_pc", o_id_ex_pc, 32'h0);
    @(negedge i_clk) i_rst = 1'b1;
    #1;
    chk("post_rst_no_stall", {31'b0, o_pc_we}, 32'h1);
    chk("post_rst_beq_taken", {31'b0, o_ctr_beq}, 32'h1);
    @(posedge i_clk);
    @(negedge i_clk) begin i_if_id_instr = 32'h00422821; i_if_id_pc = 32'h408; end
    @(posedge i_clk); #1;
    chk("post_rst_rf_cleared", o_id_ex_rs_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

MIPS ID stage: consumes the IF/ID pair (pc+4, instruction) from fetch and holds the 32x32 register file. Resolves branches and jumps in ID, detects hazards, and drives fetch's control inputs (pc_we, if_id_we, beq, jmp, flush, target addresses). It also registers the ID/EX pipeline word consumed by the execute stage.

## Interface
- NB_BITS, 32, datapath and address width
- NB_REG, 5, register-address width (32 registers)
- NB_OP, 6, opcode/funct width
- i_clk  in  1  rising-edge clock
- i_rst  in  1  asynchronous reset, active-low (asserted at 0)
- i_if_id_pc  in  NB_BITS  IF/ID pc, already pc+4
- i_if_id_instr  in  NB_BITS  IF/ID instruction (NOP = 0x00000000 after flush)
- i_ex_mem_reg_write, i_ex_mem_mem_read  in  1 each  EX/MEM writes a register / is a load
- i_ex_mem_rd  in  NB_REG  EX/MEM destination register
- i_ex_mem_data  in  NB_BITS  EX/MEM ALU result
- i_wb_we  in  1  writeback enable
- i_wb_addr  in  NB_REG  writeback register
- i_wb_data  in  NB_BITS  writeback data
- o_pc_we, o_if_id_we  out  1 each  fetch enables (0 = stall)
- o_ctr_beq, o_ctr_jmp, o_ctr_flush  out  1 each  taken branch / jump / squash IF/ID
- o_brq_addr, o_jmp_addr  out  NB_BITS  branch target / jump target
- o_id_ex_pc  out  NB_BITS  link value (if_id_pc)
- o_id_ex_rs_data, o_id_ex_rt_data, o_id_ex_imm  out  NB_BITS  operands, sign-/zero-extended imm
- o_id_ex_rs, o_id_ex_rt, o_id_ex_rd  out  NB_REG  rs, rt, final destination
- o_id_ex_opcode, o_id_ex_funct  out  NB_OP  for EX ALU decode
- o_id_ex_reg_write, o_id_ex_mem_read, o_id_ex_mem_write, o_id_ex_alu_src, o_id_ex_link  out  1 each  control

## Operation
- Supported: R-type ADDU SUBU AND OR XOR NOR SLT SLL SRL SRA JR JALR; ADDIU SLTI ANDI ORI XORI LUI LW SW BEQ BNE J JAL. Anything else decodes as bubble (all control 0).
- ANDI/ORI/XORI zero-extend imm; all others sign-extend.
- Destination: rd for R-type, rt for I-type, 31 for JAL. reg_write forced 0 when destination is 0.
- Register file: $0 reads 0 and ignores writes. Written on rising edge when i_wb_we. Read combinationally, with write-through bypass when i_wb_addr == read addr != 0.
- ID operand select for branch/JR compare: EX/MEM bypass (i_ex_mem_reg_write, !mem_read, rd match, rd != 0), else regfile/WB value.
- Stall conditions, all evaluated combinationally:
  - Load-use: registered o_id_ex_mem_read and o_id_ex_rt matches a used rs/rt of the current instruction.
  - Branch/JR source matches o_id_ex_rd with o_id_ex_reg_write.
  - Branch/JR source matches i_ex_mem_rd with i_ex_mem_mem_read.
- On stall: o_pc_we=0, o_if_id_we=0, beq/jmp/flush=0, and a bubble is registered into ID/EX.
- Branch BEQ/BNE, not stalled: o_brq_addr = i_if_id_pc + (sext(imm)<<2). If the compare is true: o_ctr_beq=1, o_ctr_flush=1.
- Jumps, not stalled:
  - J/JAL: o_jmp_addr = {i_if_id_pc[31:28], instr[25:0], 2'b00}.
  - JR/JALR: o_jmp_addr = rs operand.
  - Both: o_ctr_jmp=1, o_ctr_flush=1.
- o_ctr_beq and o_ctr_jmp are never both 1. Stall overrides branch/jump.
- JAL/JALR: o_id_ex_link=1, reg_write=1; EX writes o_id_ex_pc (no delay slot).

## Timing
- ID/EX latency: 1 cycle; registered on the rising edge after the instruction is present at IF/ID.
- Control outputs to fetch are combinational from IF/ID and the current ID/EX register, valid in the same cycle.
- Load-use costs 1 stall cycle. Branch on ALU result in ID/EX costs 1 cycle. Branch on a load costs 2 cycles. A taken branch or jump costs 1 flushed slot.
- Reset (i_rst=0), immediate and asynchronous:
  - All ID/EX outputs 0 and all registers cleared.
  - Outputs then read o_pc_we=1, o_if_id_we=1, beq=jmp=flush=0.
- Reset asserted mid-stall clears the stall source. The first cycle after release never stalls.
- Same-cycle WB write and ID read of the same register return the new data.

## Test plan
- Reset then IF/ID=0x00000000 -> o_id_ex_reg_write=0, all ID/EX control 0, o_pc_we=1.
- WB writes $3=0x10 in the same cycle as ID decodes ADDU $4,$3,$0 -> o_id_ex_rs_data=0x10 next edge.
- LW $2,0($1), then ADDU $5,$2,$2 -> one cycle with o_pc_we=o_if_id_we=0 and a bubble in ID/EX; ADDU enters ID/EX on the following edge.
- $1=$2=7, BEQ $1,$2,+4 at if_id_pc=0x104 -> o_ctr_beq=1, o_ctr_flush=1, o_brq_addr=0x114. BNE with the same operands -> o_ctr_beq=0.
- JAL 0x40 at if_id_pc=0x008 -> o_jmp_addr=0x100, o_ctr_jmp=1, next edge o_id_ex_rd=31, o_id_ex_pc=0x008, link=1.
- ADDIU $6,$0,-1 then BEQ $6,$0 -> 1 stall cycle, then EX/MEM forwarding of 0xFFFFFFFF, not taken. i_rst pulsed low mid-stall -> all outputs reset immediately.
